// File: rtl/galaga_pkg.sv
// Shared definitions for the player-side game blocks.
//   Screen bounds, sprite sizes and the state encodings used by the
//   missile controller and its per-slot tracker.
package galaga_pkg;

  localparam int unsigned ScrMinX    = 0;
  localparam int unsigned ScrMaxX    = 639;
  localparam int unsigned ScrMinY    = 0;
  localparam int unsigned ScrMaxY    = 479;

  localparam int unsigned MissileHgt = 8;
  localparam int unsigned ShipHgt    = 16;

  typedef enum logic {
    IDLE = 1'b0,
    FLY  = 1'b1
  } missile_state_e;

  typedef enum logic {
    READY    = 1'b0,
    COOLDOWN = 1'b1
  } fire_state_e;

endpackage

// File: rtl/pc_missile_slot.sv
// One missile slot: latches its spawn position and climbs StepY pixels per
// frame until it is hit or would leave the top of the playfield.
//   frame_clk_i / reset_i : frame clock, synchronous active-high reset
//   spawn_i, spawn_x_i/y_i : launch request and start position (taken only when IDLE)
//   hit_i                  : collision kill, ignored when IDLE
//   active_o, x_o, y_o     : slot in flight and its current position
//
// state | meaning
// IDLE  | slot free, x/y hold their last value
// FLY   | missile in flight, y steps up once per frame
module pc_missile_slot
  import galaga_pkg::*;
#(
  parameter int unsigned StepY = 4,
  parameter int unsigned MinY  = 0
) (
  input  logic       frame_clk_i,
  input  logic       reset_i,
  input  logic       spawn_i,
  input  logic [9:0] spawn_x_i,
  input  logic [9:0] spawn_y_i,
  input  logic       hit_i,
  output logic       active_o,
  output logic [9:0] x_o,
  output logic [9:0] y_o
);

  localparam logic [9:0] StepV  = 10'(StepY);
  // Below this the next step would cross MinY (or wrap), so the missile retires instead.
  localparam logic [9:0] FloorV = 10'(MinY + StepY);

  missile_state_e state;

  always_ff @(posedge frame_clk_i) begin
    if (reset_i) begin
      state <= IDLE;
      x_o   <= '0;
      y_o   <= '0;
    end else if (state == IDLE) begin
      if (spawn_i) begin
        state <= FLY;
        x_o   <= spawn_x_i;
        y_o   <= spawn_y_i;
      end
    end else begin
      if (hit_i || (y_o < FloorV)) begin
        state <= IDLE;
      end else begin
        y_o <= y_o - StepV;
      end
    end
  end

  assign active_o = (state == FLY);

endmodule

// File: rtl/pc_missile_ctrl.sv
// Player missile scheduler: turns fire presses into rate-limited launches,
// places each launch in the lowest free slot and steps all slots per frame.
//   frame_clk_i, reset_i       : frame clock, synchronous active-high reset
//   fire_i                     : fire button level
//   ship_xpos_i/ypos_i/size_i  : ship position and width
//   hit_i[NumSlots]            : per-slot collision kill
//   msl_active_o/xpos_o/ypos_o : slot status and packed 10-bit positions
//   launch_o                   : one-frame pulse per accepted launch
//
// state    | meaning
// READY    | a fire press with a free slot launches
// COOLDOWN | presses dropped while cool_cnt counts down to 0
module pc_missile_ctrl
  import galaga_pkg::*;
#(
  parameter int unsigned NumSlots = 2,
  parameter int unsigned StepY    = 4,
  parameter int unsigned Cooldown = 8,
  parameter int unsigned MissileH = MissileHgt,
  parameter int unsigned MinY     = ScrMinY
) (
  input  logic                     frame_clk_i,
  input  logic                     reset_i,
  input  logic                     fire_i,
  input  logic [9:0]               ship_xpos_i,
  input  logic [9:0]               ship_ypos_i,
  input  logic [9:0]               ship_size_i,
  input  logic [NumSlots-1:0]      hit_i,
  output logic [NumSlots-1:0]      msl_active_o,
  output logic [NumSlots*10-1:0]   msl_xpos_o,
  output logic [NumSlots*10-1:0]   msl_ypos_o,
  output logic                     launch_o
);

  localparam int unsigned CntW = (Cooldown > 1) ? $clog2(Cooldown) : 1;

  logic                fire_q;
  fire_state_e         fire_state;
  logic [CntW-1:0]     cool_cnt;
  logic                fire_rise;
  logic                launch;
  logic [NumSlots-1:0] free_slots;
  logic [NumSlots-1:0] spawn;
  logic [9:0]          spawn_x;
  logic [9:0]          spawn_y;

  assign fire_rise  = fire_i & ~fire_q;
  // Free mask uses registered status, so a slot retiring this frame is not reused until next frame.
  assign free_slots = ~msl_active_o;
  assign launch     = fire_rise && (fire_state == READY) && (|free_slots);
  // Isolate the lowest set bit: lowest-index free slot.
  assign spawn      = launch ? (free_slots & (~free_slots + NumSlots'(1))) : '0;
  assign spawn_x    = ship_xpos_i + {1'b0, ship_size_i[9:1]} - 10'd1;
  assign spawn_y    = ship_ypos_i - 10'(MissileH);

  always_ff @(posedge frame_clk_i) begin
    if (reset_i) begin
      fire_q     <= 1'b0;
      fire_state <= READY;
      cool_cnt   <= '0;
      launch_o   <= 1'b0;
    end else begin
      fire_q   <= fire_i;
      launch_o <= launch;
      if (fire_state == READY) begin
        if (launch) begin
          cool_cnt   <= CntW'(Cooldown - 1);
          fire_state <= COOLDOWN;
        end
      end else begin
        if (cool_cnt == '0) begin
          fire_state <= READY;
        end else begin
          cool_cnt <= cool_cnt - 1'b1;
        end
      end
    end
  end

  for (genvar k = 0; k < NumSlots; k++) begin : g_slot
    pc_missile_slot #(
      .StepY (StepY),
      .MinY  (MinY)
    ) u_slot (
      .frame_clk_i (frame_clk_i),
      .reset_i     (reset_i),
      .spawn_i     (spawn[k]),
      .spawn_x_i   (spawn_x),
      .spawn_y_i   (spawn_y),
      .hit_i       (hit_i[k]),
      .active_o    (msl_active_o[k]),
      .x_o         (msl_xpos_o[10*k +: 10]),
      .y_o         (msl_ypos_o[10*k +: 10])
    );
  end

endmodule
